// File: rtl/bcd_disp_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : bcd_disp_pkg (package)
//  Description : Shared types and constants for the binary-to-BCD converter
//                and 7-segment scan controller.
//                - state_t     : converter FSM states
//                - SEG_BLANK   : all segments off (active-low)
//                - SEG_DIGIT_n : active-low patterns {g,f,e,d,c,b,a}
//                - seg_lookup  : 16-entry nibble -> segment table
//  Revision    : 1.0  initial release
// ============================================================================
package bcd_disp_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    CONVERT = 2'd1,
    LATCH   = 2'd2
  } state_t;

  localparam logic [6:0] SEG_BLANK   = 7'h7F;

  // Active-low, bit order {g,f,e,d,c,b,a}
  localparam logic [6:0] SEG_DIGIT_0 = 7'b1000000;
  localparam logic [6:0] SEG_DIGIT_1 = 7'b1111001;
  localparam logic [6:0] SEG_DIGIT_2 = 7'b0100100;
  localparam logic [6:0] SEG_DIGIT_3 = 7'b0110000;
  localparam logic [6:0] SEG_DIGIT_4 = 7'b0011001;
  localparam logic [6:0] SEG_DIGIT_5 = 7'b0010010;
  localparam logic [6:0] SEG_DIGIT_6 = 7'b0000010;
  localparam logic [6:0] SEG_DIGIT_7 = 7'b1111000;
  localparam logic [6:0] SEG_DIGIT_8 = 7'b0000000;
  localparam logic [6:0] SEG_DIGIT_9 = 7'b0010000;

  // Codes 10..15 never come out of the converter; show them as blank.
  function automatic logic [6:0] seg_lookup(input logic [3:0] nib);
    logic [6:0] r;
    case (nib)
      4'd0:    r = SEG_DIGIT_0;
      4'd1:    r = SEG_DIGIT_1;
      4'd2:    r = SEG_DIGIT_2;
      4'd3:    r = SEG_DIGIT_3;
      4'd4:    r = SEG_DIGIT_4;
      4'd5:    r = SEG_DIGIT_5;
      4'd6:    r = SEG_DIGIT_6;
      4'd7:    r = SEG_DIGIT_7;
      4'd8:    r = SEG_DIGIT_8;
      4'd9:    r = SEG_DIGIT_9;
      default: r = SEG_BLANK;
    endcase
    return r;
  endfunction

endpackage
`default_nettype wire

// File: rtl/bcd_seg_decoder.sv
`default_nettype none
// ============================================================================
//  Module      : bcd_seg_decoder
//  Description : Combinational BCD nibble to active-low 7-segment decoder.
//  Ports       : digit_i [3:0]  BCD nibble
//                seg_o   [6:0]  segments {g,f,e,d,c,b,a}, active-low
//  Revision    : 1.0  initial release
// ============================================================================
import bcd_disp_pkg::*;

module bcd_seg_decoder (
  input  logic [3:0] digit_i,
  output logic [6:0] seg_o
);

  always_comb begin
    seg_o = seg_lookup(digit_i);
  end

endmodule
`default_nettype wire

// File: rtl/bcd_convert_scan_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : bcd_convert_scan_ctrl
//  Description : Sequential double-dabble binary-to-BCD converter (one shift
//                per clock) with a latched result register and a free-running
//                4-digit common-anode 7-segment scan controller.
//  Ports       : clk      system clock, rising edge
//                reset    asynchronous active-high reset
//                start    conversion request, sampled only in IDLE
//                bin_in   unsigned binary input, captured on accepted start
//                busy     high from cycle after accepted start to done cycle
//                done     one-cycle pulse, bcd_out valid from same cycle
//                bcd_out  latched result {thousands,hundreds,tens,units}
//                an       digit enables, active-low one-hot (an[0] = units)
//                seg      segments {g,f,e,d,c,b,a}, active-low
//  Options     : BCD_LEADING_ZERO_BLANK_EN - blank digits above the most
//                significant nonzero digit (units digit always shown).
//  Revision    : 1.0  initial release
// ============================================================================
import bcd_disp_pkg::*;

module bcd_convert_scan_ctrl #(
  parameter int BIN_W       = 10,
  parameter int DIGITS      = 4,
  parameter int REFRESH_DIV = 50000
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  start,
  input  logic [BIN_W-1:0]      bin_in,
  output logic                  busy,
  output logic                  done,
  output logic [4*DIGITS-1:0]   bcd_out,
  output logic [DIGITS-1:0]     an,
  output logic [6:0]            seg
);

  localparam int BCD_W = 4 * DIGITS;
  localparam int SR_W  = BCD_W + BIN_W;
  localparam int CNT_W = $clog2(BIN_W + 1);
  localparam int REF_W = $clog2(REFRESH_DIV);
  localparam int IDX_W = $clog2(DIGITS);

  localparam logic [CNT_W-1:0] ITER_ONE  = CNT_W'(1);
  localparam logic [CNT_W-1:0] ITER_LAST = CNT_W'(BIN_W - 1);
  localparam logic [REF_W-1:0] REF_ONE   = REF_W'(1);
  localparam logic [REF_W-1:0] REF_LAST  = REF_W'(REFRESH_DIV - 1);
  localparam logic [IDX_W-1:0] IDX_ONE   = IDX_W'(1);
  localparam logic [IDX_W-1:0] IDX_LAST  = IDX_W'(DIGITS - 1);

  // --------------------------------------------------------------------------
  // Elaboration-time parameter checks
  // --------------------------------------------------------------------------
  if (BIN_W > 13 || BIN_W < 1) begin : g_bin_w_check
    $error("BIN_W must be 1..13 so the result fits in 4 BCD digits");
  end
  if (DIGITS != 4) begin : g_digits_check
    $error("DIGITS is fixed at 4 in this revision");
  end
  if (REFRESH_DIV < 2) begin : g_refresh_check
    $error("REFRESH_DIV must be >= 2");
  end

  // --------------------------------------------------------------------------
  // Converter state
  // --------------------------------------------------------------------------
  state_t             state_q, state_d;
  logic [SR_W-1:0]    sr_q,    sr_d;
  logic [CNT_W-1:0]   iter_q,  iter_d;
  logic [BCD_W-1:0]   bcd_q,   bcd_d;
  logic               done_q,  done_d;
  logic [SR_W-1:0]    w_sr_adj;

  // Add-3 correction on every BCD nibble that is >= 5, before the shift.
  // The 4-bit add deliberately drops the carry: a nibble of 5..9 plus 3 stays
  // within 8..12, and the following shift carries its MSB into the next digit.
  always_comb begin
    w_sr_adj = sr_q;
    for (int i = 0; i < DIGITS; i++) begin
      if (sr_q[BIN_W + 4*i +: 4] >= 4'd5) begin
        w_sr_adj[BIN_W + 4*i +: 4] = sr_q[BIN_W + 4*i +: 4] + 4'd3;
      end
    end
  end

  always_comb begin
    state_d = state_q;
    sr_d    = sr_q;
    iter_d  = iter_q;
    bcd_d   = bcd_q;
    done_d  = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (start) begin
          sr_d    = {{BCD_W{1'b0}}, bin_in};
          iter_d  = '0;
          state_d = CONVERT;
        end
      end
      CONVERT: begin
        sr_d   = {w_sr_adj[SR_W-2:0], 1'b0};
        iter_d = iter_q + ITER_ONE;
        if (iter_q == ITER_LAST) begin
          state_d = LATCH;
        end
      end
      LATCH: begin
        // Result register only changes here, so the display never sees a
        // partially converted value.
        bcd_d   = sr_q[SR_W-1 -: BCD_W];
        done_d  = 1'b1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      sr_q    <= '0;
      iter_q  <= '0;
      bcd_q   <= '0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      sr_q    <= sr_d;
      iter_q  <= iter_d;
      bcd_q   <= bcd_d;
      done_q  <= done_d;
    end
  end

  // The FSM is already back in IDLE during the done cycle, so busy must
  // include done_q explicitly to stay high through that cycle.
  assign busy    = (state_q != IDLE) | done_q;
  assign done    = done_q;
  assign bcd_out = bcd_q;

  // --------------------------------------------------------------------------
  // Display scan
  // --------------------------------------------------------------------------
  logic [REF_W-1:0]   ref_q, ref_d;
  logic [IDX_W-1:0]   idx_q, idx_d;
  logic [DIGITS-1:0]  an_q,  an_d;
  logic [6:0]         seg_q, seg_d;
  logic [3:0]         w_nibble;
  logic [6:0]         w_seg_raw;
  logic               w_blank;

  always_comb begin
    ref_d = ref_q + REF_ONE;
    idx_d = idx_q;
    if (ref_q == REF_LAST) begin
      ref_d = '0;
      idx_d = (idx_q == IDX_LAST) ? '0 : idx_q + IDX_ONE;
    end
  end

  // Mux on the next index so seg and an update on the same edge.
  always_comb begin
    w_nibble = '0;
    for (int i = 0; i < DIGITS; i++) begin
      if (idx_d == IDX_W'(i)) begin
        w_nibble = bcd_q[4*i +: 4];
      end
    end
  end

  bcd_seg_decoder u_seg_decoder (
    .digit_i (w_nibble),
    .seg_o   (w_seg_raw)
  );

`ifdef BCD_LEADING_ZERO_BLANK_EN
  // w_upper_zero[i]: digit i and every digit above it are zero.
  logic [DIGITS-1:0] w_upper_zero;
  always_comb begin
    w_upper_zero[DIGITS-1] = (bcd_q[BCD_W-1 -: 4] == 4'd0);
    for (int i = DIGITS-2; i >= 0; i--) begin
      w_upper_zero[i] = w_upper_zero[i+1] && (bcd_q[4*i +: 4] == 4'd0);
    end
  end
  assign w_blank = (idx_d != '0) && w_upper_zero[idx_d];
`else
  assign w_blank = 1'b0;
`endif

  always_comb begin
    an_d  = ~({{(DIGITS-1){1'b0}}, 1'b1} << idx_d);
    seg_d = w_blank ? SEG_BLANK : w_seg_raw;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      ref_q <= '0;
      idx_q <= '0;
      an_q  <= {{(DIGITS-1){1'b1}}, 1'b0};
      seg_q <= SEG_DIGIT_0;
    end else begin
      ref_q <= ref_d;
      idx_q <= idx_d;
      an_q  <= an_d;
      seg_q <= seg_d;
    end
  end

  assign an  = an_q;
  assign seg = seg_q;

endmodule
`default_nettype wire

// File: tb/tb_bcd_convert_scan_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : tb_bcd_convert_scan_ctrl
//  Description : Self-checking bench for bcd_convert_scan_ctrl. A cycle-level
//                behavioural model (countdown to done, integer display value,
//                decimal digit extraction) is compared against every output
//                on every falling edge, alongside directed literal checks.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_bcd_convert_scan_ctrl;

  localparam int BIN_W  = 10;
  localparam int DIGITS = 4;
  localparam int RDIV   = 4;

  logic              clk = 1'b0;
  logic              reset;
  logic              start;
  logic [BIN_W-1:0]  bin_in;
  logic              busy;
  logic              done;
  logic [15:0]       bcd_out;
  logic [3:0]        an;
  logic [6:0]        seg;

  int checks   = 0;
  int failures = 0;
  bit chk_en   = 1'b0;

`ifdef BCD_LEADING_ZERO_BLANK_EN
  localparam logic [6:0] TOP_ZERO_SEG = 7'b1111111;
`else
  localparam logic [6:0] TOP_ZERO_SEG = 7'b1000000;
`endif

  always #5 clk = ~clk;

  bcd_convert_scan_ctrl #(
    .BIN_W       (BIN_W),
    .DIGITS      (DIGITS),
    .REFRESH_DIV (RDIV)
  ) dut (
    .clk     (clk),
    .reset   (reset),
    .start   (start),
    .bin_in  (bin_in),
    .busy    (busy),
    .done    (done),
    .bcd_out (bcd_out),
    .an      (an),
    .seg     (seg)
  );

  // ---------------- reference helpers ----------------
  function automatic int pow10(input int i);
    case (i)
      0: return 1;
      1: return 10;
      2: return 100;
      default: return 1000;
    endcase
  endfunction

  function automatic logic [15:0] to_bcd(input int v);
    return {4'(v / 1000 % 10), 4'(v / 100 % 10), 4'(v / 10 % 10), 4'(v % 10)};
  endfunction

  function automatic logic [6:0] seg_of(input int d);
    case (d)
      0: return 7'b1000000;
      1: return 7'b1111001;
      2: return 7'b0100100;
      3: return 7'b0110000;
      4: return 7'b0011001;
      5: return 7'b0010010;
      6: return 7'b0000010;
      7: return 7'b1111000;
      8: return 7'b0000000;
      9: return 7'b0010000;
      default: return 7'h7F;
    endcase
  endfunction

  function automatic logic [6:0] exp_seg(input int val, input int idx);
`ifdef BCD_LEADING_ZERO_BLANK_EN
    if (idx > 0 && val < pow10(idx)) return 7'h7F;
`endif
    return seg_of((val / pow10(idx)) % 10);
  endfunction

  function automatic logic [3:0] exp_an(input int idx);
    return ~(4'b0001 << idx);
  endfunction

  task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      if (failures <= 40)
        $display("FAIL %s actual=%h required=%h time=%0t", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  // m_cnt: clocks remaining until the done pulse (0 = idle/ready).
  int         m_cnt, m_val, m_disp, m_tick, m_idx;
  logic       m_done;
  logic [6:0] m_seg;

  always @(posedge clk or posedge reset) begin
    if (reset) begin
      m_cnt  <= 0;
      m_val  <= 0;
      m_disp <= 0;
      m_tick <= 0;
      m_idx  <= 0;
      m_done <= 1'b0;
      m_seg  <= 7'b1000000;
    end else begin
      m_done <= (m_cnt == 1);
      if (m_cnt == 0) begin
        if (start) begin
          m_val <= int'(bin_in);
          m_cnt <= BIN_W + 1;
        end
      end else begin
        m_cnt <= m_cnt - 1;
        if (m_cnt == 1) m_disp <= m_val;
      end
      if (m_tick == RDIV - 1) begin
        m_tick <= 0;
        m_idx  <= (m_idx + 1) % DIGITS;
      end else begin
        m_tick <= m_tick + 1;
      end
      // seg reflects the result held before this edge at the new index
      m_seg <= exp_seg(m_disp, (m_tick == RDIV - 1) ? (m_idx + 1) % DIGITS : m_idx);
    end
  end

  // ---------------- per-cycle compare ----------------
  always @(negedge clk) begin
    if (chk_en) begin
      check("model_busy", 16'(busy), 16'((m_cnt != 0) || m_done));
      check("model_done", 16'(done), 16'(m_done));
      check("model_bcd",  bcd_out,   to_bcd(m_disp));
      check("model_an",   16'(an),   16'(exp_an(m_idx)));
      check("model_seg",  16'(seg),  16'(m_seg));
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic do_start(input int v);
    @(posedge clk); #1;
    start  = 1'b1;
    bin_in = BIN_W'(v);
    @(posedge clk); #1;
    start  = 1'b0;
  endtask

  // n = number of falling edges seen up to and including the done cycle
  task automatic wait_done(output int n, output int nbusy);
    n = 0;
    nbusy = 0;
    for (int i = 1; i <= 40; i++) begin
      @(negedge clk);
      if (busy) nbusy++;
      if (done) begin
        n = i;
        break;
      end
    end
    if (n == 0) begin
      checks++;
      failures++;
      $display("FAIL done_timeout actual=none required=done within 40 cycles");
    end
  endtask

  task automatic wait_an(input logic [3:0] pat);
    bit seen;
    seen = 1'b0;
    for (int i = 0; i < 64; i++) begin
      @(negedge clk);
      if (an == pat) begin
        seen = 1'b1;
        break;
      end
    end
    if (!seen) begin
      checks++;
      failures++;
      $display("FAIL an_timeout actual=%b required=%b", an, pat);
    end
  endtask

  // ---------------- directed + random sequence ----------------
  initial begin
    int n, nb, ndone;
    logic [3:0] an_lit  [4];
    logic [6:0] seg_lit [4];
    int bvals [9];

    an_lit  = '{4'b1110, 4'b1101, 4'b1011, 4'b0111};
    seg_lit = '{7'b0010000, 7'b0011001, 7'b1111000, TOP_ZERO_SEG};
    bvals   = '{0, 1, 9, 10, 99, 100, 999, 1000, 1023};

    start  = 1'b0;
    bin_in = '0;
    reset  = 1'b0;
    #1 reset = 1'b1;
    chk_en = 1'b1;

    // 1: reset state
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_busy", 16'(busy), 16'd0);
    check("rst_done", 16'(done), 16'd0);
    check("rst_bcd",  bcd_out,   16'h0000);
    check("rst_an",   16'(an),   16'b1110);
    check("rst_seg",  16'(seg),  16'b1000000);
    #2 reset = 1'b0;

    // 2: full-scale value and latency
    do_start(1023);
    wait_done(n, nb);
    check("t2_latency", 16'(n - 1), 16'd11);
    check("t2_busy_cycles", 16'(nb), 16'd12);
    check("t2_bcd", bcd_out, 16'h1023);
    @(negedge clk);
    check("t2_busy_drop", 16'(busy), 16'd0);

    // 3: zero value, upper digit rendering
    do_start(0);
    wait_done(n, nb);
    check("t3_bcd", bcd_out, 16'h0000);
    wait_an(4'b1101);
    check("t3_seg_tens", 16'(seg), 16'(TOP_ZERO_SEG));

    // 4: start while busy ignored; start in done cycle accepted
    do_start(749);
    repeat (3) @(negedge clk);
    @(posedge clk); #1;
    start = 1'b1; bin_in = BIN_W'(5);
    @(posedge clk); #1;
    start = 1'b0; bin_in = BIN_W'(333);
    wait_done(n, nb);
    check("t4_ignored", bcd_out, 16'h0749);
    start = 1'b1; bin_in = BIN_W'(5);
    @(posedge clk); #1;
    start = 1'b0; bin_in = BIN_W'(871);
    wait_done(n, nb);
    check("t4_b2b_latency", 16'(n - 1), 16'd11);
    check("t4_b2b_bcd", bcd_out, 16'h0005);

    // 5: scan sequence for 749
    do_start(749);
    wait_done(n, nb);
    wait_an(4'b0111);
    wait_an(4'b1110);
    for (int i = 0; i < 16; i++) begin
      check("t5_an",  16'(an),  16'(an_lit[i / 4]));
      check("t5_seg", 16'(seg), 16'(seg_lit[i / 4]));
      @(negedge clk);
    end

    // 6: reset mid-conversion
    do_start(512);
    repeat (4) @(negedge clk);
    #2 reset = 1'b1;
    #1;
    check("t6_busy", 16'(busy), 16'd0);
    check("t6_done", 16'(done), 16'd0);
    check("t6_bcd",  bcd_out,   16'h0000);
    @(negedge clk);
    #2 reset = 1'b0;
    ndone = 0;
    for (int i = 0; i < 15; i++) begin
      @(negedge clk);
      if (done) ndone++;
    end
    check("t6_no_done", 16'(ndone), 16'd0);
    do_start(512);
    wait_done(n, nb);
    check("t6_restart", bcd_out, 16'h0512);

    // Random traffic: starts at random times (many while busy), bin_in
    // changing every cycle, biased toward decimal boundary values.
    for (int c = 0; c < 1500; c++) begin
      @(posedge clk); #1;
      start = ($urandom_range(0, 5) == 0);
      if ($urandom_range(0, 3) == 0)
        bin_in = BIN_W'(bvals[$urandom_range(0, 8)]);
      else
        bin_in = BIN_W'($urandom_range(0, 1023));
    end
    start = 1'b0;
    repeat (20) @(posedge clk);
    @(negedge clk);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire
